muldiv_unit: RTL

// Iterative unsigned multiply/divide unit that sits beside the Alu in the

---
 rtl/muldiv_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: radix-2 shift-add multiply and restoring division,
// one bit per cycle, with a single-cycle shortcut for divide by zero.
module muldiv_unit #(
  parameter int unsigned Bits = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [Bits-1:0] src_a_i,
  input  logic [Bits-1:0] src_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [Bits-1:0] result_o,
  output logic            result_zero_o
);

  localparam int unsigned CntW = $clog2(Bits + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDivZero, StDone} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [1:0]          op_q;
  logic [Bits-1:0]     a_q, b_q;
  logic [2*Bits-1:0]   acc_q;
  logic                busy_q, done_q, result_zero_q;
  logic [Bits-1:0]     result_q;

  logic [Bits:0]       mul_sum, div_shift;
  logic [Bits-1:0]     div_diff;
  logic                div_ge;
  logic [2*Bits-1:0]   acc_d;
  logic [Bits-1:0]     a_d, b_d, fin_d, dz_result;

  // acc_q: multiply -> {partial high, product low}; divide -> {remainder, quotient}.
  // a_q doubles as the dividend shift register, b_q as the multiplier shift register.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*Bits-1:Bits]} + {1'b0, (b_q[0] ? a_q : {Bits{1'b0}})};
    div_shift = {acc_q[2*Bits-1:Bits], a_q[Bits-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    // When the trial succeeds the difference is below the divisor, so Bits bits suffice.
    div_diff  = div_shift[Bits-1:0] - b_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    if (op_q[1]) begin
      acc_d = {(div_ge ? div_diff : div_shift[Bits-1:0]), acc_q[Bits-2:0], div_ge};
      a_d   = a_q << 1;
    end else begin
      acc_d = {mul_sum, acc_q[Bits-1:1]};
      b_d   = b_q >> 1;
    end
    unique case (op_q)
      2'b00:   fin_d = acc_d[Bits-1:0];
      2'b01:   fin_d = acc_d[2*Bits-1:Bits];
      2'b10:   fin_d = acc_d[Bits-1:0];
      default: fin_d = acc_d[2*Bits-1:Bits];
    endcase
    dz_result = op_q[0] ? a_q : {Bits{1'b1}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      result_zero_q <= 1'b1;
    end else if (flush_i) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            op_q   <= op_i;
            a_q    <= src_a_i;
            b_q    <= src_b_i;
            acc_q  <= '0;
            cnt_q  <= CntW'(Bits);
            done_q <= 1'b0;
            if (op_i[1] && (src_b_i == '0)) begin
              state_q <= StDivZero;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end
        end
        StDivZero: begin
          state_q       <= StDone;
          done_q        <= 1'b1;
          result_q      <= dz_result;
          result_zero_q <= (dz_result == '0);
        end
        StRun: begin
          acc_q <= acc_d;
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q       <= StDone;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            result_q      <= fin_d;
            result_zero_q <= (fin_d == '0);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign result_zero_o = result_zero_q;

endmodule
